// File: rtl/pe_pkg.sv
// Shared types and saturating-add helpers for the weight-stationary MAC PE.
package pe_pkg;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mac_mode_e;

    localparam int MAX_ACC_W = 64;

    typedef logic [MAX_ACC_W:0] wide_t;

    localparam wide_t W_ONE = wide_t'(1);

    function automatic logic [MAX_ACC_W-1:0] acc_max(
        input logic sgn,
        input int   acc_w
    );
        wide_t lim;
        lim = (W_ONE << (sgn ? acc_w - 1 : acc_w)) - W_ONE;
        return lim[MAX_ACC_W-1:0];
    endfunction

    function automatic logic [MAX_ACC_W-1:0] acc_min(
        input logic sgn,
        input int   acc_w
    );
        return sgn ? ~acc_max(1'b1, acc_w) : '0;
    endfunction

    // Operands arrive already extended to MAX_ACC_W+1 bits; returns {flag, value}.
    function automatic wide_t sat_add(
        input wide_t a,
        input wide_t b,
        input logic  sgn,
        input int    acc_w,
        input logic  sat_en
    );
        wide_t                sum;
        wide_t                hi;
        wide_t                lo;
        logic [MAX_ACC_W-1:0] mn;
        logic                 over;
        logic                 under;
        sum   = a + b;
        hi    = {1'b0, acc_max(sgn, acc_w)};
        mn    = acc_min(sgn, acc_w);
        lo    = {mn[MAX_ACC_W-1], mn};
        over  = sgn ? ($signed(sum) > $signed(hi)) : (sum > hi);
        under = sgn && ($signed(sum) < $signed(lo));
        if (sat_en && over) begin
            return {1'b1, hi[MAX_ACC_W-1:0]};
        end
        if (sat_en && under) begin
            return {1'b1, lo[MAX_ACC_W-1:0]};
        end
        return {1'b0, sum[MAX_ACC_W-1:0]};
    endfunction

endpackage

// File: rtl/wsmac_pe_if.sv
// Sample, result and weight-chain signals of one MAC PE.
interface wsmac_pe_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SEL_W  = 2
);
    logic              load_en;
    logic [DATA_W-1:0] wt_in;
    logic [DATA_W-1:0] wt_out;
    logic              wt_ready;
    logic [SEL_W-1:0]  wt_sel;
    logic              signed_mode;
    logic              in_valid;
    logic [DATA_W-1:0] data_in;
    logic [ACC_W-1:0]  acc_in;
    logic [DATA_W-1:0] data_out;
    logic [ACC_W-1:0]  acc_out;
    logic              out_valid;
    logic              sat_flag;

    modport master (
        output load_en, wt_in, wt_sel, signed_mode,
        output in_valid, data_in, acc_in,
        input  wt_out, wt_ready, data_out,
        input  acc_out, out_valid, sat_flag
    );

    modport slave (
        input  load_en, wt_in, wt_sel, signed_mode,
        input  in_valid, data_in, acc_in,
        output wt_out, wt_ready, data_out,
        output acc_out, out_valid, sat_flag
    );
endinterface

// File: rtl/mac_wt_bank.sv
// Stationary weight register file with daisy-chain load and
// a read mux that returns zero for out-of-range indices.
module mac_wt_bank #(
    parameter int DATA_W = 8,
    parameter int NUM_WT = 4,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [DATA_W-1:0] wt_in,
    output logic [DATA_W-1:0] wt_out,
    output logic              wt_ready,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [DATA_W-1:0] rd_wt
);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_WT - 1);
    localparam logic [SEL_W-1:0] INC  = SEL_W'(1);

    logic [DATA_W-1:0] bank [NUM_WT];
    logic [SEL_W-1:0]  load_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_ptr <= '0;
            wt_ready <= 1'b0;
            wt_out   <= '0;
            for (int i = 0; i < NUM_WT; i++) begin
                bank[i] <= '0;
            end
        end else if (load_en) begin
            wt_out <= wt_in;
            for (int i = 0; i < NUM_WT; i++) begin
                if (load_ptr == SEL_W'(i)) begin
                    bank[i] <= wt_in;
                end
            end
            // Last-entry check first so a single-entry bank still sets ready.
            if (load_ptr == LAST) begin
                load_ptr <= '0;
                wt_ready <= 1'b1;
            end else begin
                load_ptr <= load_ptr + INC;
                if (load_ptr == '0) begin
                    wt_ready <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_wt = '0;
        for (int i = 0; i < NUM_WT; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_wt = bank[i];
            end
        end
    end

endmodule

// File: rtl/wsmac_pe.sv
// Weight-stationary MAC PE: weight bank plus a 2-stage
// multiply / accumulate pipeline with optional saturation.
module wsmac_pe
    import pe_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int NUM_WT   = 4,
    parameter int SATURATE = 1,
    localparam int SEL_W   = (NUM_WT > 1) ? $clog2(NUM_WT) : 1
) (
    input logic       clk,
    input logic       rst,
    wsmac_pe_if.slave pe
);
    localparam int PW = 2 * DATA_W;

    logic [DATA_W-1:0] wt;
    logic              sgn_in;
    logic [PW-1:0]     data_x;
    logic [PW-1:0]     wt_x;
    logic [PW-1:0]     prod;

    logic              s1_valid;
    logic [PW-1:0]     s1_prod;
    logic [ACC_W-1:0]  s1_acc;
    mac_mode_e         s1_mode;
    logic              s1_sgn;

    wide_t             acc_x;
    wide_t             prod_x;
    wide_t             res;
    logic              unused_res;

    logic [DATA_W-1:0] data_q;
    logic [ACC_W-1:0]  acc_q;
    logic              valid_q;
    logic              sat_q;

    mac_wt_bank #(
        .DATA_W (DATA_W),
        .NUM_WT (NUM_WT),
        .SEL_W  (SEL_W)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .load_en  (pe.load_en),
        .wt_in    (pe.wt_in),
        .wt_out   (pe.wt_out),
        .wt_ready (pe.wt_ready),
        .rd_sel   (pe.wt_sel),
        .rd_wt    (wt)
    );

    // Extending both operands to 2*DATA_W makes the low half of one
    // multiplier correct for either signedness.
    assign sgn_in = pe.signed_mode;
    assign data_x = {{DATA_W{sgn_in & pe.data_in[DATA_W-1]}}, pe.data_in};
    assign wt_x   = {{DATA_W{sgn_in & wt[DATA_W-1]}}, wt};
    assign prod   = data_x * wt_x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_acc   <= '0;
            s1_mode  <= MODE_UNSIGNED;
            data_q   <= '0;
        end else if (pe.load_en) begin
            s1_valid <= 1'b0;
            data_q   <= '0;
        end else begin
            data_q   <= pe.data_in;
            s1_valid <= pe.in_valid;
            if (pe.in_valid) begin
                s1_prod <= prod;
                s1_acc  <= pe.acc_in;
                s1_mode <= mac_mode_e'(sgn_in);
            end
        end
    end

    assign s1_sgn = (s1_mode == MODE_SIGNED);

    always_comb begin
        acc_x  = {{(MAX_ACC_W + 1 - ACC_W){s1_sgn & s1_acc[ACC_W-1]}},
                  s1_acc};
        prod_x = {{(MAX_ACC_W + 1 - PW){s1_sgn & s1_prod[PW-1]}},
                  s1_prod};
        res    = sat_add(acc_x, prod_x, s1_sgn, ACC_W, SATURATE != 0);
    end

    assign unused_res = ^res;

    // Stage 2 ignores load_en so an in-flight sample always completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            valid_q <= s1_valid;
            if (s1_valid) begin
                acc_q <= res[ACC_W-1:0];
                sat_q <= res[MAX_ACC_W];
            end else begin
                sat_q <= 1'b0;
            end
        end
    end

    assign pe.data_out  = data_q;
    assign pe.acc_out   = acc_q;
    assign pe.out_valid = valid_q;
    assign pe.sat_flag  = sat_q;

endmodule

// File: tb/tb_wsmac_pe.sv
// Scoreboard bench: 32-bit saturating PE plus a pair of 16-bit
// PEs (saturating / wrapping) sharing stimulus.
module tb_wsmac_pe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] acc;
        logic        sat;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    logic [7:0] wl [4] = '{8'h03, 8'hFE, 8'h05, 8'h07};
    logic [7:0] wb [3] = '{8'h07, 8'hFE, 8'h05};

    wsmac_pe_if #(.DATA_W(8), .ACC_W(32), .SEL_W(2)) ia ();
    wsmac_pe_if #(.DATA_W(8), .ACC_W(16), .SEL_W(2)) ib ();
    wsmac_pe_if #(.DATA_W(8), .ACC_W(16), .SEL_W(2)) ic ();

    wsmac_pe #(.DATA_W(8), .ACC_W(32), .NUM_WT(4), .SATURATE(1)) ua (
        .clk (clk), .rst (rst), .pe (ia)
    );
    wsmac_pe #(.DATA_W(8), .ACC_W(16), .NUM_WT(3), .SATURATE(1)) ub (
        .clk (clk), .rst (rst), .pe (ib)
    );
    wsmac_pe #(.DATA_W(8), .ACC_W(16), .NUM_WT(3), .SATURATE(0)) uc (
        .clk (clk), .rst (rst), .pe (ic)
    );

    assign ic.load_en     = ib.load_en;
    assign ic.wt_in       = ib.wt_in;
    assign ic.wt_sel      = ib.wt_sel;
    assign ic.signed_mode = ib.signed_mode;
    assign ic.in_valid    = ib.in_valid;
    assign ic.data_in     = ib.data_in;
    assign ic.acc_in      = ib.acc_in;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic a_step(input logic ld, input logic [7:0] w,
                          input logic v, input logic [1:0] sel,
                          input logic sm, input logic [7:0] d,
                          input logic [31:0] acc,
                          input logic [31:0] e_acc, input logic e_sat);
        ia.load_en     = ld;
        ia.wt_in       = w;
        ia.in_valid    = v;
        ia.wt_sel      = sel;
        ia.signed_mode = sm;
        ia.data_in     = d;
        ia.acc_in      = acc;
        if (v && !ld) qa.push_back('{acc: e_acc, sat: e_sat, cyc: cyc + 2});
        @(negedge clk);
    endtask

    task automatic b_step(input logic ld, input logic [7:0] w,
                          input logic v, input logic [1:0] sel,
                          input logic sm, input logic [7:0] d,
                          input logic [15:0] acc,
                          input logic [15:0] eb, input logic eb_sat,
                          input logic [15:0] ec, input logic ec_sat);
        ib.load_en     = ld;
        ib.wt_in       = w;
        ib.in_valid    = v;
        ib.wt_sel      = sel;
        ib.signed_mode = sm;
        ib.data_in     = d;
        ib.acc_in      = acc;
        if (v && !ld) begin
            qb.push_back('{acc: {16'h0, eb}, sat: eb_sat, cyc: cyc + 2});
            qc.push_back('{acc: {16'h0, ec}, sat: ec_sat, cyc: cyc + 2});
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && ia.out_valid) begin
            if (qa.size() == 0) begin
                chk("a unexpected out_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a acc_out", 64'(ia.acc_out), 64'(e.acc));
                chk("a sat_flag", 64'(ia.sat_flag), 64'(e.sat));
                chk("a latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ib.out_valid) begin
            if (qb.size() == 0) begin
                chk("b unexpected out_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b acc_out", 64'(ib.acc_out), 64'(e.acc));
                chk("b sat_flag", 64'(ib.sat_flag), 64'(e.sat));
                chk("b latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ic.out_valid) begin
            if (qc.size() == 0) begin
                chk("c unexpected out_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = qc.pop_front();
                chk("c acc_out", 64'(ic.acc_out), 64'(e.acc));
                chk("c sat_flag", 64'(ic.sat_flag), 64'(e.sat));
                chk("c latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        ia.load_en = 0; ia.wt_in = 0; ia.in_valid = 0; ia.wt_sel = 0;
        ia.signed_mode = 0; ia.data_in = 0; ia.acc_in = 0;
        ib.load_en = 0; ib.wt_in = 0; ib.in_valid = 0; ib.wt_sel = 0;
        ib.signed_mode = 0; ib.data_in = 0; ib.acc_in = 0;
        repeat (2) @(negedge clk);
        chk("rst acc_out", 64'(ia.acc_out), 64'd0);
        chk("rst out_valid", 64'(ia.out_valid), 64'd0);
        chk("rst data_out", 64'(ia.data_out), 64'd0);
        chk("rst wt_out", 64'(ia.wt_out), 64'd0);
        chk("rst wt_ready", 64'(ia.wt_ready), 64'd0);
        chk("rst sat_flag", 64'(ia.sat_flag), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // weight load with ignored in_valid pulses
        for (int i = 0; i < 4; i++) begin
            a_step(1, wl[i], 1, 0, 0, 8'hAA, 32'd5, 0, 0);
            chk("a load wt_out", 64'(ia.wt_out), 64'(wl[i]));
            chk("a load wt_ready", 64'(ia.wt_ready), (i == 3) ? 64'd1 : 64'd0);
            chk("a load data_out", 64'(ia.data_out), 64'd0);
        end

        // signed MAC
        a_step(0, 0, 1, 1, 1, 8'h10, 32'd100, 32'd68, 0);
        chk("a data_out pass", 64'(ia.data_out), 64'h10);
        repeat (3) a_step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // unsigned MAC then back-to-back samples
        a_step(0, 0, 1, 1, 0, 8'h10, 32'd100, 32'd4164, 0);
        a_step(0, 0, 1, 0, 0, 8'h01, 32'd0, 32'd3, 0);
        a_step(0, 0, 1, 2, 0, 8'h01, 32'd0, 32'd5, 0);
        a_step(0, 0, 1, 3, 0, 8'h01, 32'd0, 32'd7, 0);
        a_step(0, 0, 1, 3, 1, 8'hFF, 32'd0, 32'hFFFF_FFF9, 0);
        repeat (3) a_step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // load overlapping an in-flight sample
        a_step(0, 0, 1, 0, 0, 8'h02, 32'd1, 32'd7, 0);
        a_step(1, 8'h09, 1, 0, 0, 8'h55, 32'd999, 0, 0);
        chk("a ovl wt_out", 64'(ia.wt_out), 64'h09);
        chk("a ovl wt_ready", 64'(ia.wt_ready), 64'd0);
        chk("a ovl data_out", 64'(ia.data_out), 64'd0);
        a_step(0, 0, 1, 0, 0, 8'h01, 32'd0, 32'd9, 0);
        repeat (3) a_step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 16-bit pair: saturate vs wrap
        for (int i = 0; i < 3; i++) begin
            b_step(1, wb[i], 0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("b load wt_out", 64'(ib.wt_out), 64'(wb[i]));
            chk("b load wt_ready", 64'(ib.wt_ready), (i == 2) ? 64'd1 : 64'd0);
        end
        b_step(0, 0, 1, 0, 1, 8'h05, 16'd32760, 16'h7FFF, 1, 16'h801B, 0);
        b_step(0, 0, 1, 1, 1, 8'h01, 16'h8000, 16'h8000, 1, 16'h7FFE, 0);
        b_step(0, 0, 1, 1, 0, 8'h01, 16'hFFFF, 16'hFFFF, 1, 16'h00FD, 0);
        b_step(0, 0, 1, 3, 0, 8'h05, 16'd10, 16'd10, 0, 16'd10, 0);
        b_step(0, 0, 1, 2, 1, 8'hFD, 16'd20, 16'd5, 0, 16'd5, 0);
        repeat (3) b_step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // async reset mid-load and mid-pipeline
        a_step(1, 8'h11, 0, 0, 0, 0, 0, 0, 0);
        a_step(1, 8'h22, 0, 0, 0, 0, 0, 0, 0);
        a_step(0, 0, 1, 1, 0, 8'h33, 32'd1, 0, 0);
        #2 rst = 1'b1;
        #1;
        qa.delete();
        chk("arst acc_out", 64'(ia.acc_out), 64'd0);
        chk("arst data_out", 64'(ia.data_out), 64'd0);
        chk("arst wt_out", 64'(ia.wt_out), 64'd0);
        chk("arst out_valid", 64'(ia.out_valid), 64'd0);
        chk("arst b wt_ready", 64'(ib.wt_ready), 64'd0);
        chk("arst b acc_out", 64'(ib.acc_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_step(1, 8'(i + 1), 0, 0, 0, 0, 0, 0, 0);
            chk("a reload wt_out", 64'(ia.wt_out), 64'(i + 1));
            chk("a reload wt_ready", 64'(ia.wt_ready), (i == 3) ? 64'd1 : 64'd0);
        end
        a_step(0, 0, 1, 3, 0, 8'h01, 32'd0, 32'd4, 0);
        a_step(0, 0, 1, 0, 0, 8'h01, 32'd0, 32'd1, 0);
        repeat (4) a_step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        chk("a queue drained", 64'(qa.size()), 64'd0);
        chk("b queue drained", 64'(qb.size()), 64'd0);
        chk("c queue drained", 64'(qc.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wsmac_pe.md
Name: wsmac_pe

Overview:
Weight-stationary MAC processing element for the convolution systolic array. It is the parametrised successor of the single-weight PE and adds:
- a bank of NUM_WT stationary weights, with per-sample selection;
- a runtime signed/unsigned mode;
- a 2-stage pipelined multiply-accumulate with valid tracking;
- optional saturation.

The weight daisy-chain and the horizontal activation pass-through are retained so PEs tile into rows and columns unchanged.

Parameters:
DATA_W, 8, activation/weight width
ACC_W, 32, accumulator width (must be >= 2*DATA_W)
NUM_WT, 4, stationary weights per PE (>= 1)
SATURATE, 1, 1 = clamp on overflow, 0 = wrap modulo 2^ACC_W
SEL_W, $clog2(NUM_WT) min 1, derived; width of wt_sel

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-high
load_en  in  1  weight-load cycle; suppresses compute
wt_in  in  DATA_W  weight chain input
wt_out  out  DATA_W  weight chain output (registered wt_in)
wt_ready  out  1  all NUM_WT bank entries loaded since last load start
wt_sel  in  SEL_W  bank index applied to current sample
signed_mode  in  1  1 = two's complement operands, 0 = unsigned
in_valid  in  1  data_in/acc_in carry a sample
data_in  in  DATA_W  activation in
acc_in  in  ACC_W  partial sum in
data_out  out  DATA_W  activation pass-through
acc_out  out  ACC_W  acc_in + data_in*weight
out_valid  out  1  acc_out holds a new result
sat_flag  out  1  result was clamped (qualified by out_valid)

Behaviour:
- Reset (async, any time, including mid-load or mid-pipeline): all outputs 0; bank entries 0; load_ptr 0; wt_ready 0; stage-1 valid 0.
- Weight load, every edge with load_en=1:
  - bank[load_ptr] <= wt_in; wt_out <= wt_in.
  - load_ptr increments and wraps NUM_WT-1 -> 0.
  - A write at load_ptr==0 clears wt_ready. A write at load_ptr==NUM_WT-1 sets wt_ready (NUM_WT=1: the same write sets it).
  - wt_out holds its value when load_en=0.
- A weight written at edge t is used by samples captured at edge t+1 onward.
- Load priority: with load_en=1, in_valid is ignored (sample dropped), stage-1 valid <= 0, data_out <= 0.
- Stage 1, on an edge with load_en=0:
  - data_out <= data_in, regardless of in_valid (latency 1).
  - If in_valid=1: register the product data_in*bank[wt_sel], acc_in and signed_mode; s1_valid <= 1. Otherwise s1_valid <= 0.
  - wt_sel >= NUM_WT selects weight 0x0.
- Arithmetic:
  - signed_mode=1: both operands signed; the 2*DATA_W product is sign-extended to ACC_W; acc_in is signed.
  - signed_mode=0: everything is zero-extended.
  - The sum is computed at ACC_W+1 bits.
- Stage 2, evaluated every edge regardless of load_en, so an in-flight sample always completes:
  - out_valid <= s1_valid.
  - If s1_valid: acc_out <= result and sat_flag <= overflow. Otherwise acc_out holds and sat_flag <= 0.
  - acc_out latency is 2 cycles from the sample edge.
- Saturation (SATURATE=1):
  - Signed overflow clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - Unsigned carry-out clamps to 2^ACC_W-1.
  - SATURATE=0: result wraps and sat_flag is always 0.
- The integrator must skew acc_in by 2 cycles per PE relative to data_in. The block itself does no alignment.
- Back-to-back valid samples every cycle are supported: throughput 1/cycle.

Decomposition:
- Package pe_pkg:
  - mac_mode_e (MODE_UNSIGNED=0, MODE_SIGNED=1);
  - functions acc_max(signed, ACC_W) and acc_min(signed, ACC_W);
  - a sat_add function returning {flag, value}.
- Sub-module mac_wt_bank: holds the register file, load_ptr, wt_ready, wt_out and the read mux with the out-of-range-to-zero rule.
- The top level holds the two pipeline stages.

Test Plan:
- Load: load_en for 4 cycles, wt_in = 0x03, 0xFE, 0x05, 0x07 -> wt_out echoes each value 1 cycle later; wt_ready=1 after the 4th edge; in_valid pulses during the load produce no out_valid.
- Signed MAC: wt_sel=1, signed_mode=1, data_in=0x10, acc_in=100, in_valid for 1 cycle -> data_out=0x10 at +1; acc_out=68, out_valid=1 at +2; out_valid=0 at +3.
- Unsigned MAC: same stimulus with signed_mode=0 -> acc_out=4164 (254*16+100); back-to-back samples with wt_sel=0,2,3 and data=1, acc_in=0 -> acc_out = 3, 5, 7 on consecutive cycles.
- Saturation (ACC_W=16): wt=7, data=5, acc_in=32760, signed. SATURATE=1 -> acc_out=32767, sat_flag=1. SATURATE=0 -> acc_out=-32741, sat_flag=0. Signed acc_in=-32768 with wt=0xFE, data=1 (SATURATE=1) -> acc_out=-32768, sat_flag=1.
- Load/compute overlap: valid sample at edge t, load_en=1 at t+1 -> result still delivered at t+2; a sample presented with load_en=1 is dropped, and the bank write goes to the current load_ptr.
- Reset: assert rst mid-pipeline (asynchronously, between edges) and after 2 of 4 weight writes -> all outputs 0 immediately; the next load starts at entry 0; wt_ready stays 0 until 4 further writes.
